// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: multiplier FSM states, default
// operand width and the bit-counter sizing helper.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MAC_WIDTH = 8;

    // The counter must hold WIDTH itself, hence the +1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mac_seq_multiplier_if.sv
// Controller-to-multiplier link: operand/strobe lines from the controller,
// done flag and product back from the multiplier.
interface mac_seq_multiplier_if
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
);
    logic                 RESET_cmd;
    logic                 Load_op;
    logic                 Begin_mul;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 End_mul;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output RESET_cmd, Load_op, Begin_mul, a_in, b_in,
        input  End_mul, product
    );

    modport slave (
        input  RESET_cmd, Load_op, Begin_mul, a_in, b_in,
        output End_mul, product
    );
endinterface

// File: rtl/mac_seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per cycle,
// WIDTH iterations, result held in DONE until the controller moves on.
module mac_seq_multiplier
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_seq_multiplier_if.slave  bus
);

    localparam int CW = count_width(WIDTH);

    mul_state_t             state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CW-1:0]          count_q, count_d;
    logic [2*WIDTH-1:0]     product_q, product_d;

    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     step;

    // One add-shift step: the carry out of the add becomes the new top bit.
    assign sum  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, a_q} : '0);
    assign step = {sum, mplier_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        if (!bus.RESET_cmd) begin
            state_d   = IDLE;
            a_d       = '0;
            b_d       = '0;
            acc_d     = '0;
            mplier_d  = '0;
            count_d   = '0;
            product_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.Load_op) begin
                        a_d = bus.a_in;
                        b_d = bus.b_in;
                        if (state_q == DONE) state_d = IDLE;
                    end
                    // Same-cycle load and start must multiply the fresh operands.
                    if (bus.Begin_mul) begin
                        state_d  = BUSY;
                        acc_d    = '0;
                        mplier_d = bus.Load_op ? bus.b_in : b_q;
                        count_d  = CW'(WIDTH);
                    end
                end
                BUSY: begin
                    {acc_d, mplier_d} = step;
                    count_d           = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        product_d = step;
                        state_d   = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.End_mul = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_mac_seq_multiplier.sv
// Scoreboard bench for mac_seq_multiplier: expected products are queued when a
// multiply is started and compared when End_mul is observed.
module tb_mac_seq_multiplier;
    import mac_pkg::*;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    mac_seq_multiplier_if #(.WIDTH(W)) bus ();

    mac_seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_in    = a;
        bus.b_in    = b;
        bus.Load_op = 1'b1;
        tick();
        bus.Load_op = 1'b0;
    endtask

    // Returns after the edge that samples Begin_mul, i.e. in BUSY cycle 1.
    task automatic start_mul(input logic [31:0] exp, input bit push);
        if (push) exp_q.push_back(exp);
        bus.Begin_mul = 1'b1;
        tick();
        bus.Begin_mul = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int elapsed);
        int n;
        logic [31:0] exp;
        n = elapsed;
        while (!bus.End_mul && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, W + 1);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 32'(bus.product), exp);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.RESET_cmd = 1'b1;
        bus.Load_op   = 1'b0;
        bus.Begin_mul = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        #12;
        check("reset_end_mul", 32'(bus.End_mul), 0);
        check("reset_product", 32'(bus.product), 0);
        reset = 1'b1;
        tick();

        // Basic multiply
        load_ops(8'd13, 8'd11);
        start_mul(143, 1);
        wait_result("mul_13x11", 1);

        // Max operands; product must hold the previous result while busy
        load_ops(8'd255, 8'd255);
        start_mul(65025, 1);
        check("hold_prev_product", 32'(bus.product), 143);
        check("busy_end_mul_low", 32'(bus.End_mul), 0);
        wait_result("mul_255x255", 1);

        load_ops(8'd0, 8'd200);
        start_mul(0, 1);
        wait_result("mul_0x200", 1);

        // Strobes during BUSY are ignored
        load_ops(8'd7, 8'd6);
        start_mul(42, 1);
        tick();
        tick();
        bus.a_in      = 8'd3;
        bus.b_in      = 8'd3;
        bus.Load_op   = 1'b1;
        bus.Begin_mul = 1'b1;
        tick();
        bus.Load_op   = 1'b0;
        bus.Begin_mul = 1'b0;
        wait_result("mul_busy_strobes", 4);
        start_mul(42, 1);
        wait_result("mul_rerun", 1);

        // Combined load+start in DONE uses fresh operands
        bus.a_in      = 8'd12;
        bus.b_in      = 8'd10;
        bus.Load_op   = 1'b1;
        exp_q.push_back(120);
        bus.Begin_mul = 1'b1;
        tick();
        bus.Load_op   = 1'b0;
        bus.Begin_mul = 1'b0;
        wait_result("mul_load_and_begin", 1);

        // Synchronous clear mid-BUSY, then operands must be zero
        load_ops(8'd100, 8'd100);
        start_mul(0, 0);
        tick();
        tick();
        tick();
        bus.RESET_cmd = 1'b0;
        tick();
        bus.RESET_cmd = 1'b1;
        check("sclr_end_mul", 32'(bus.End_mul), 0);
        check("sclr_product", 32'(bus.product), 0);
        tick();
        check("sclr_stays_idle", 32'(bus.End_mul), 0);
        start_mul(0, 1);
        wait_result("mul_after_sclr_zero_ops", 1);
        load_ops(8'd5, 8'd5);
        start_mul(25, 1);
        wait_result("mul_5x5", 1);

        // Asynchronous reset between edges
        load_ops(8'd200, 8'd3);
        start_mul(0, 0);
        tick();
        tick();
        #4;
        reset = 1'b0;
        #1;
        check("areset_end_mul", 32'(bus.End_mul), 0);
        check("areset_product", 32'(bus.product), 0);
        #2;
        reset = 1'b1;
        tick();
        check("areset_idle", 32'(bus.End_mul), 0);
        load_ops(8'd9, 8'd9);
        start_mul(81, 1);
        wait_result("mul_9x9", 1);

        // Controller cadence: LOAD / RUN / TEST / ADD rounds
        for (int i = 0; i < 10; i++) begin
            logic [15:0] held;
            bus.a_in    = W'(i);
            bus.b_in    = W'(i + 1);
            bus.Load_op = 1'b1;
            tick();
            bus.Load_op = 1'b0;
            check($sformatf("run_end_mul_low_%0d", i), 32'(bus.End_mul), 0);
            start_mul(32'(i * (i + 1)), 1);
            wait_result($sformatf("cadence_%0d", i), 1);
            held = bus.product;
            tick();
            check($sformatf("add_end_mul_%0d", i), 32'(bus.End_mul), 1);
            check($sformatf("add_product_stable_%0d", i), 32'(bus.product), 32'(held));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
